// File: rtl/ca_sweep_engine.sv
// Double-buffered, row-sweeping, bit-packed 2-state cellular-automaton engine.
// Outer-totalistic rule and edge mode are latched at start; VGA always reads the front buffer.
module ca_sweep_engine #(
    parameter int CELL_W = 20,
    parameter int COLS   = 64,
    parameter int ROWS   = 1024,
    parameter int ADDR_W = $clog2(COLS*ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wrap_mode,
    input  logic [8:0]        birth_mask,
    input  logic [8:0]        survive_mask,
    output logic              busy,
    output logic              done,
    output logic [15:0]       gen_count,
    output logic              front_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [CELL_W-1:0] host_data,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [CELL_W-1:0] vga_q
);

    localparam int NWORDS = COLS*ROWS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int K_W    = $clog2(COLS+1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS-1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(COLS);
    localparam logic [K_W-1:0]   LAST_COL = K_W'(COLS-1);

    typedef enum logic [2:0] {S_IDLE, S_READ_T, S_READ_M, S_READ_B, S_ROW_END, S_DONE} state_t;
    typedef logic [2:0][CELL_W-1:0] window_t;   // [0]=word k-2, [1]=k-1, [2]=k

    logic [CELL_W-1:0] mem0 [NWORDS];
    logic [CELL_W-1:0] mem1 [NWORDS];
    // Shadow of bit CELL_W-1 of each row's last word, so the wrapped column -1 is
    // available at row start without spending a RAM read.
    logic              edge0 [ROWS];
    logic              edge1 [ROWS];

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              wrap_q, wrap_d;
    logic [8:0]        birth_q, birth_d, surv_q, surv_d;
    logic              busy_q, busy_d, done_q, done_d, front_q, front_d;
    logic [15:0]       gen_q, gen_d;
    logic              zero_q, zero_d;
    window_t           win_t_q, win_t_d, win_m_q, win_m_d, win_b_q, win_b_d;
    logic [CELL_W-1:0] rd_data_q, vga_rd_q;

    logic [ROW_W-1:0]  row_up, row_dn, rd_row, host_row;
    logic [K_W-1:0]    rd_col, wr_col;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [CELL_W-1:0] land, wr_data, pre_up, pre_mid, pre_dn;
    logic              col_zero, eng_we, host_wr, host_last_col;
    logic              edge_up, edge_mid, edge_dn;

    function automatic logic [CELL_W-1:0] next_word(input window_t t, input window_t m,
                                                    input window_t b, input logic [8:0] bm,
                                                    input logic [8:0] sm);
        logic [CELL_W+1:0] et, em, eb;
        logic [3:0]        n;
        logic [CELL_W-1:0] res;
        et = {t[2][0], t[1], t[0][CELL_W-1]};
        em = {m[2][0], m[1], m[0][CELL_W-1]};
        eb = {b[2][0], b[1], b[0][CELL_W-1]};
        for (int i = 0; i < CELL_W; i++) begin
            n = 4'(et[i]) + 4'(et[i+1]) + 4'(et[i+2]) + 4'(em[i]) + 4'(em[i+2])
              + 4'(eb[i]) + 4'(eb[i+1]) + 4'(eb[i+2]);
            res[i] = em[i+1] ? sm[n] : bm[n];
        end
        return res;
    endfunction

    assign row_up   = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
    assign row_dn   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
    assign col_zero = (k_q == LAST_K) && !wrap_q;
    assign rd_col   = (k_q == LAST_K) ? '0 : k_q;
    assign rd_addr  = ADDR_W'(rd_row) * ADDR_W'(COLS) + ADDR_W'(rd_col);
    assign wr_addr  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(wr_col);
    assign land     = zero_q ? '0 : rd_data_q;
    assign edge_up  = front_q ? edge1[row_up] : edge0[row_up];
    assign edge_mid = front_q ? edge1[row_q]  : edge0[row_q];
    assign edge_dn  = front_q ? edge1[row_dn] : edge0[row_dn];
    assign pre_up   = wrap_q ? {edge_up,  {(CELL_W-1){1'b0}}} : '0;
    assign pre_mid  = wrap_q ? {edge_mid, {(CELL_W-1){1'b0}}} : '0;
    assign pre_dn   = wrap_q ? {edge_dn,  {(CELL_W-1){1'b0}}} : '0;
    assign host_wr  = host_we && !busy_q;
    assign host_row = ROW_W'(host_addr / ADDR_W'(COLS));
    assign host_last_col = (host_addr % ADDR_W'(COLS)) == ADDR_W'(COLS-1);
    assign wr_data  = next_word(win_t_q, win_m_q, win_b_d, birth_q, surv_q);

    always_comb begin
        state_d = state_q;  row_d = row_q;      k_d = k_q;
        wrap_d = wrap_q;    birth_d = birth_q;  surv_d = surv_q;
        busy_d = busy_q;    done_d = 1'b0;      gen_d = gen_q;
        front_d = front_q;  zero_d = 1'b0;
        win_t_d = win_t_q;  win_m_d = win_m_q;  win_b_d = win_b_q;
        rd_row = row_q;     eng_we = 1'b0;      wr_col = '0;
        case (state_q)
            S_IDLE: if (start) begin
                wrap_d = wrap_mode;  birth_d = birth_mask;  surv_d = survive_mask;
                busy_d = 1'b1;  row_d = '0;  k_d = '0;  state_d = S_READ_T;
            end
            S_READ_T: begin
                rd_row = row_up;
                zero_d = col_zero || (row_q == '0 && !wrap_q);
                if (k_q == '0) begin
                    win_t_d[2] = pre_up;  win_m_d[2] = pre_mid;  win_b_d[2] = pre_dn;
                end else begin
                    win_b_d = {land, win_b_q[2:1]};
                end
                if (k_q >= K_W'(2)) begin
                    eng_we = 1'b1;
                    wr_col = k_q - K_W'(2);
                end
                state_d = S_READ_M;
            end
            S_READ_M: begin
                zero_d  = col_zero;
                win_t_d = {land, win_t_q[2:1]};
                state_d = S_READ_B;
            end
            S_READ_B: begin
                rd_row  = row_dn;
                zero_d  = col_zero || (row_q == LAST_ROW && !wrap_q);
                win_m_d = {land, win_m_q[2:1]};
                if (k_q == LAST_K) begin
                    state_d = S_ROW_END;
                end else begin
                    k_d = k_q + 1'b1;
                    state_d = S_READ_T;
                end
            end
            S_ROW_END: begin
                win_b_d = {land, win_b_q[2:1]};
                eng_we  = 1'b1;
                wr_col  = LAST_COL;
                k_d     = '0;
                if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q + 1'b1;
                    state_d = S_READ_T;
                end
            end
            S_DONE: begin
                front_d = ~front_q;  gen_d = gen_q + 16'd1;
                done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;  row_q <= '0;  k_q <= '0;
            wrap_q <= 1'b0;  birth_q <= '0;  surv_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  gen_q <= '0;  front_q <= 1'b0;
            zero_q <= 1'b0;  win_t_q <= '0;  win_m_q <= '0;  win_b_q <= '0;
            vga_rd_q <= '0;
        end else begin
            state_q <= state_d;  row_q <= row_d;  k_q <= k_d;
            wrap_q <= wrap_d;  birth_q <= birth_d;  surv_q <= surv_d;
            busy_q <= busy_d;  done_q <= done_d;  gen_q <= gen_d;  front_q <= front_d;
            zero_q <= zero_d;  win_t_q <= win_t_d;  win_m_q <= win_m_d;  win_b_q <= win_b_d;
            vga_rd_q <= front_q ? mem1[vga_addr] : mem0[vga_addr];
        end
    end

    // Host writes the front buffer, the engine writes the back buffer; never both at once.
    always_ff @(posedge clk) begin
        rd_data_q <= front_q ? mem1[rd_addr] : mem0[rd_addr];
        if (host_wr) begin
            if (front_q) mem1[host_addr] <= host_data;
            else         mem0[host_addr] <= host_data;
            if (host_last_col) begin
                if (front_q) edge1[host_row] <= host_data[CELL_W-1];
                else         edge0[host_row] <= host_data[CELL_W-1];
            end
        end
        if (eng_we) begin
            if (front_q) mem0[wr_addr] <= wr_data;
            else         mem1[wr_addr] <= wr_data;
            if (wr_col == LAST_COL) begin
                if (front_q) edge0[row_q] <= wr_data[CELL_W-1];
                else         edge1[row_q] <= wr_data[CELL_W-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;
    assign front_sel = front_q;
    assign vga_q     = vga_rd_q;

endmodule

// File: tb/tb_ca_sweep_engine.sv
// Bench for ca_sweep_engine on an 8x32 grid: directed patterns plus random grids and
// rules compared against a cell-by-cell reference model.
module tb_ca_sweep_engine;
    localparam int CELL_W = 8, COLS = 4, ROWS = 8, ADDR_W = 5;
    localparam int NW = COLS*ROWS, NCOL = COLS*CELL_W, LAT = 129;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wrap_mode = 1'b0;
    logic [8:0] birth_mask = '0, survive_mask = '0;
    logic busy, done, front_sel, host_we = 1'b0;
    logic [15:0] gen_count;
    logic [ADDR_W-1:0] host_addr = '0, vga_addr = '0;
    logic [CELL_W-1:0] host_data = '0, vga_q;

    int checks = 0, errors = 0;
    logic [CELL_W-1:0] img [NW];
    logic [CELL_W-1:0] got [NW];
    logic [15:0] exp_gen;
    logic exp_front;

    ca_sweep_engine #(.CELL_W(CELL_W), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .wrap_mode(wrap_mode),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .busy(busy), .done(done),
        .gen_count(gen_count), .front_sel(front_sel), .host_we(host_we),
        .host_addr(host_addr), .host_data(host_data), .vga_addr(vga_addr), .vga_q(vga_q));

    always #5 clk = ~clk;

    function automatic bit cell_at(input int r, input int c, input bit wrap);
        if (r < 0 || r >= ROWS || c < 0 || c >= NCOL) begin
            if (!wrap) return 1'b0;
            r = (r + ROWS) % ROWS;
            c = (c + NCOL) % NCOL;
        end
        return img[r*COLS + c/CELL_W][c%CELL_W];
    endfunction

    task automatic model_step(input bit wrap, input logic [8:0] bm, input logic [8:0] sm);
        logic [CELL_W-1:0] nxt [NW];
        int n;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < NCOL; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(cell_at(r+dr, c+dc, wrap));
                nxt[r*COLS + c/CELL_W][c%CELL_W] = cell_at(r, c, wrap) ? sm[n] : bm[n];
            end
        img = nxt;
    endtask

    task automatic clear_img();
        for (int a = 0; a < NW; a++) img[a] = '0;
    endtask

    task automatic random_img();
        for (int a = 0; a < NW; a++) img[a] = CELL_W'($urandom & $urandom);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; host_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_gen = '0; exp_front = 1'b0;
    endtask

    task automatic load_img();
        for (int a = 0; a < NW; a++) begin
            @(negedge clk);
            host_we = 1'b1; host_addr = ADDR_W'(a); host_data = img[a];
        end
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic read_front();
        @(negedge clk);
        vga_addr = '0;
        for (int a = 0; a < NW; a++) begin
            @(negedge clk);
            got[a] = vga_q;
            if (a + 1 < NW) vga_addr = ADDR_W'(a + 1);
        end
    endtask

    // Rule inputs are scrambled after the start cycle so only latched values matter.
    task automatic run_gen(input bit wrap, input logic [8:0] bm, input logic [8:0] sm,
                           input bit we, input int wa, input logic [CELL_W-1:0] wd,
                           output int cyc);
        @(negedge clk);
        start = 1'b1; wrap_mode = wrap; birth_mask = bm; survive_mask = sm;
        host_we = we; host_addr = ADDR_W'(wa); host_data = wd;
        @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        wrap_mode = ~wrap; birth_mask = ~bm; survive_mask = ~sm;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        exp_gen++;
        exp_front = ~exp_front;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen got %0d expected 0", gen_count); end
        if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front got %b expected 0", front_sel); end
        if (vga_q !== '0) begin errors++; $display("FAIL reset_vga got %h expected 00", vga_q); end
        reset = 1'b0;
    endtask

    task automatic test_blinker();
        int cyc;
        apply_reset(); clear_img(); img[13] = 8'h0E; load_img();
        run_gen(1'b0, 9'h008, 9'h00C, 1'b0, 0, '0, cyc);
        clear_img(); img[9] = 8'h04; img[13] = 8'h04; img[17] = 8'h04;
        checks += 3;
        if (cyc != LAT) begin errors++; $display("FAIL blinker_latency got %0d expected %0d", cyc, LAT); end
        if (gen_count !== 16'd1) begin errors++; $display("FAIL blinker_gen got %0d expected 1", gen_count); end
        if (front_sel !== 1'b1) begin errors++; $display("FAIL blinker_front got %b expected 1", front_sel); end
        read_front();
        for (int a = 0; a < NW; a++) begin
            checks++;
            if (got[a] !== img[a]) begin errors++; $display("FAIL blinker word %0d got %h expected %h", a, got[a], img[a]); end
        end
    endtask

    task automatic test_block();
        int cyc;
        apply_reset(); clear_img();
        img[8] = 8'h80; img[9] = 8'h01; img[12] = 8'h80; img[13] = 8'h01;
        load_img();
        for (int g = 1; g <= 3; g++) begin
            run_gen(1'b0, 9'h008, 9'h00C, 1'b0, 0, '0, cyc);
            checks += 2;
            if (cyc != LAT) begin errors++; $display("FAIL block_latency got %0d expected %0d", cyc, LAT); end
            if (gen_count !== 16'(g)) begin errors++; $display("FAIL block_gen got %0d expected %0d", gen_count, g); end
            read_front();
            for (int a = 0; a < NW; a++) begin
                checks++;
                if (got[a] !== img[a]) begin errors++; $display("FAIL block g%0d word %0d got %h expected %h", g, a, got[a], img[a]); end
            end
        end
    endtask

    task automatic test_edge();
        int cyc;
        for (int w = 0; w < 2; w++) begin
            apply_reset(); clear_img();
            img[12] = 8'h01; img[16] = 8'h01; img[20] = 8'h01;
            load_img();
            run_gen(w[0], 9'h008, 9'h00C, 1'b0, 0, '0, cyc);
            clear_img(); img[16] = 8'h03;
            if (w == 1) img[19] = 8'h80;
            read_front();
            for (int a = 0; a < NW; a++) begin
                checks++;
                if (got[a] !== img[a]) begin errors++; $display("FAIL edge wrap%0d word %0d got %h expected %h", w, a, got[a], img[a]); end
            end
        end
    endtask

    task automatic test_rules();
        int cyc;
        apply_reset(); random_img(); load_img();
        run_gen(1'($urandom), 9'h000, 9'h000, 1'b0, 0, '0, cyc);
        read_front();
        for (int a = 0; a < NW; a++) begin
            checks++;
            if (got[a] !== '0) begin errors++; $display("FAIL rule_zero word %0d got %h expected 00", a, got[a]); end
        end
        clear_img(); img[17] = 8'h10; load_img();
        run_gen(1'b0, 9'h002, 9'h000, 1'b0, 0, '0, cyc);
        clear_img(); img[13] = 8'h38; img[17] = 8'h28; img[21] = 8'h38;
        read_front();
        checks++;
        if (gen_count !== 16'd2) begin errors++; $display("FAIL rule_gen got %0d expected 2", gen_count); end
        for (int a = 0; a < NW; a++) begin
            checks++;
            if (got[a] !== img[a]) begin errors++; $display("FAIL rule_b1 word %0d got %h expected %h", a, got[a], img[a]); end
        end
    endtask

    task automatic test_start_with_write();
        int cyc;
        apply_reset(); clear_img(); img[13] = 8'h0A; load_img();
        run_gen(1'b0, 9'h008, 9'h00C, 1'b1, 13, 8'h0E, cyc);
        clear_img(); img[9] = 8'h04; img[13] = 8'h04; img[17] = 8'h04;
        checks++;
        if (cyc != LAT) begin errors++; $display("FAIL startwr_latency got %0d expected %0d", cyc, LAT); end
        read_front();
        for (int a = 0; a < NW; a++) begin
            checks++;
            if (got[a] !== img[a]) begin errors++; $display("FAIL startwr word %0d got %h expected %h", a, got[a], img[a]); end
        end
    endtask

    task automatic test_handshake();
        int cyc, extra_done;
        bit seen;
        apply_reset(); clear_img(); img[13] = 8'h0E; load_img();
        @(negedge clk);
        vga_addr = 5'd13; start = 1'b1; wrap_mode = 1'b0; birth_mask = 9'h008; survive_mask = 9'h00C;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy got %b expected 1", busy); end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (vga_q !== 8'h0E) begin errors++; $display("FAIL hs_vga_old cycle %0d got %h expected 0e", cyc, vga_q); end
            if (done === 1'b1) seen = 1'b1;
            start = (cyc == 40);
            host_we = (cyc == 60); host_addr = 5'd13; host_data = 8'hFF;
        end
        host_we = 1'b0;
        @(negedge clk);
        checks += 2;
        if (cyc != LAT) begin errors++; $display("FAIL hs_latency got %0d expected %0d", cyc, LAT); end
        if (vga_q !== 8'h04) begin errors++; $display("FAIL hs_vga_new got %h expected 04", vga_q); end
        extra_done = 0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        checks += 3;
        if (extra_done != 0) begin errors++; $display("FAIL hs_extra_done got %0d expected 0", extra_done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle_busy got %b expected 0", busy); end
        if (gen_count !== 16'd1) begin errors++; $display("FAIL hs_gen got %0d expected 1", gen_count); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset(); random_img(); load_img();
        @(negedge clk);
        start = 1'b1; wrap_mode = 1'b1; birth_mask = 9'h008; survive_mask = 9'h00C;
        @(negedge clk);
        start = 1'b0;
        repeat (64) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b expected 0", done); end
        if (gen_count !== 16'd0) begin errors++; $display("FAIL mid_gen got %0d expected 0", gen_count); end
        if (front_sel !== 1'b0) begin errors++; $display("FAIL mid_front got %b expected 0", front_sel); end
        if (vga_q !== '0) begin errors++; $display("FAIL mid_vga got %h expected 00", vga_q); end
        @(negedge clk);
        reset = 1'b0; exp_gen = '0; exp_front = 1'b0;
        run_gen(1'b0, 9'h008, 9'h00C, 1'b0, 0, '0, cyc);
        model_step(1'b0, 9'h008, 9'h00C);
        checks += 3;
        if (cyc != LAT) begin errors++; $display("FAIL mid_latency got %0d expected %0d", cyc, LAT); end
        if (gen_count !== 16'd1) begin errors++; $display("FAIL mid_gen_after got %0d expected 1", gen_count); end
        if (front_sel !== 1'b1) begin errors++; $display("FAIL mid_front_after got %b expected 1", front_sel); end
        read_front();
        for (int a = 0; a < NW; a++) begin
            checks++;
            if (got[a] !== img[a]) begin errors++; $display("FAIL mid word %0d got %h expected %h", a, got[a], img[a]); end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit wrap;
        logic [8:0] bm, sm;
        apply_reset(); random_img(); load_img();
        for (int i = 0; i < 6; i++) begin
            wrap = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin bm = 9'h008; sm = 9'h00C; end
            else begin bm = 9'($urandom) & 9'h1FE; sm = 9'($urandom); end
            run_gen(wrap, bm, sm, 1'b0, 0, '0, cyc);
            model_step(wrap, bm, sm);
            checks += 3;
            if (cyc != LAT) begin errors++; $display("FAIL rnd_latency got %0d expected %0d", cyc, LAT); end
            if (gen_count !== exp_gen) begin errors++; $display("FAIL rnd_gen got %0d expected %0d", gen_count, exp_gen); end
            if (front_sel !== exp_front) begin errors++; $display("FAIL rnd_front got %b expected %b", front_sel, exp_front); end
            read_front();
            for (int a = 0; a < NW; a++) begin
                checks++;
                if (got[a] !== img[a]) begin errors++; $display("FAIL rnd%0d word %0d got %h expected %h", i, a, got[a], img[a]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_edge();
        test_rules();
        test_start_with_write();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_sweep_engine.md
Name: ca_sweep_engine

Overview:
- Parametrised successor to the Conway accelerator manager: a double-buffered, row-sweeping, bit-packed 2-state cellular-automaton engine with a runtime-selectable outer-totalistic rule.
- Selectable edge mode: dead border or toroidal wrap.
- Owns both grid buffers: host load port, start/done handshake, and a VGA read port that always sees the last completed generation (front buffer).

Parameters:
- CELL_W, 20, cells per memory word.
- COLS, 64, words per grid row.
- ROWS, 1024, grid rows.
- ADDR_W, $clog2(COLS*ROWS), derived; word address = row*COLS + col.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to compute one generation.
- wrap_mode  in  1  0 = dead border, 1 = toroidal; sampled at start.
- birth_mask  in  9  bit n set: dead cell with n live neighbours is born; sampled at start.
- survive_mask  in  9  bit n set: live cell with n live neighbours survives; sampled at start.
- busy  out  1  generation in progress.
- done  out  1  one-cycle pulse when a generation completes.
- gen_count  out  16  completed generations, wraps at 65535 to 0.
- front_sel  out  1  buffer index currently shown (0 = buf0, 1 = buf1).
- host_we  in  1  host write into the front buffer.
- host_addr  in  ADDR_W  host write address.
- host_data  in  CELL_W  host write data.
- vga_addr  in  ADDR_W  display read address.
- vga_q  out  CELL_W  front-buffer word; registered, 1-cycle latency.

Behaviour:
- Reset values: busy=0, done=0, gen_count=0, front_sel=0, vga_q=0, FSM=IDLE. RAM contents are not cleared. Reset mid-generation aborts the sweep, discards partial back-buffer data and returns front_sel to 0.
- Cell layout: bit 0 of word c is grid column c*CELL_W; bit CELL_W-1 is the rightmost column. The left neighbour of bit 0 is bit CELL_W-1 of word c-1.
- Edge handling:
  - Row -1, row ROWS, col word -1 and col word COLS read as all-zero when wrap_mode=0.
  - When wrap_mode=1 they map modulo ROWS / COLS.
  - Border words are substituted as zero without a RAM access.
- FSM states:
  - IDLE: start=1 -> latch rule and mode, set busy=1, row=0, k=0, go to READ_T. start while busy is ignored.
  - READ_T, READ_M, READ_B: each state issues one read of the back-source (front) buffer for rows row-1, row, row+1 at column word k. k=COLS maps to word 0 in wrap mode, zero in dead mode. Synchronous RAM, 1-cycle read latency.
  - Three-row window: each row keeps a shift window of words k-2, k-1, k. Column word -1 is preloaded per edge mode at row start.
  - Step k done: after the READ_B data for step k lands, k increments and control returns to READ_T. For k>=1, output word k-1 is computed from the window and written to the back buffer at address row*COLS+(k-1) during the next READ_T cycle.
  - Row end: after step k=COLS, go to ROW_END. ROW_END performs the final write of the row, clears k and increments row.
  - Sweep end: ROW_END with row=ROWS-1 goes to DONE instead of READ_T.
  - DONE: toggle front_sel, increment gen_count, pulse done for 1 cycle, clear busy, return to IDLE.
- Generation latency: start accepted to done asserted = ROWS*(3*(COLS+1)+1) + 1 cycles, exactly.
- Next-state rule: for each cell, n = live count of its 8 neighbours (0..8). next = cell ? survive_mask[n] : birth_mask[n].
- Host writes go to the front buffer only while busy=0. They are ignored (dropped) while busy=1.
- Port conflicts:
  - The VGA read port is independent and dual-ported against the engine; it always reads buffer front_sel.
  - A host write and a VGA read to the same address in the same cycle return the old data.
  - A front_sel toggle takes effect on the VGA read issued the cycle after done.
- Simultaneous start and host_we in IDLE: the write is performed, then the generation starts, and the sweep sees the written data.

Test Plan:
- Bench parameters: CELL_W=8, COLS=4, ROWS=8, wrap_mode=0, B3/S23 (birth_mask=9'h008, survive_mask=9'h00C). Blinker at row 3, cols 9-11 (word 13 = 8'h0E); start -> done exactly 129 cycles after start. Front buffer then has words 9, 13 and 17 = 8'h04, all other words 0. gen_count=1, front_sel=1.
- Cross-word block, same bench parameters: cells (2,7), (2,8), (3,7), (3,8), i.e. word 8 = 8'h80, word 9 = 8'h01, word 12 = 8'h80, word 13 = 8'h01. Run 3 generations -> pattern unchanged each time, gen_count=3.
- Edge, dead mode: vertical blinker at col 0, rows 3-5 -> after 1 generation only row 4 has cells: word 16 = 8'h03, word 19 = 0. Same stimulus with wrap_mode=1 -> word 16 = 8'h03, word 19 = 8'h80, rows 3 and 5 empty.
- Rule masks: birth_mask=0 and survive_mask=0 on a random grid -> all words 0. Single cell with birth_mask=9'h002 (B1), survive_mask=0 -> the 8 surrounding cells are set and the centre is cleared.
- Handshake: start pulsed while busy is ignored, gen_count increments once. host_we while busy is dropped and the front buffer is unchanged. vga_q returns the pre-generation image until done, and the new image starting the cycle after done.
- Reset mid-operation: assert reset halfway through a generation -> busy=0, done=0, gen_count=0, front_sel=0 in the same cycle. A following start completes normally in exactly 129 cycles.
